// File: rtl/cache_axi_arbiter_pkg.sv
// Shared types and AXI constants for the cache-to-AXI arbiter.
// ARB_RR_EN (defined in the top) selects round-robin read arbitration.
package cache_axi_arbiter_pkg;

  localparam int          BURST_LEN_DEF = 4;
  localparam logic [3:0]  ARLEN         = 4'(BURST_LEN_DEF - 1);
  localparam logic [3:0]  AWLEN         = 4'(BURST_LEN_DEF - 1);
  localparam logic [2:0]  AXSIZE_WORD   = 3'd2;
  localparam logic [1:0]  BURST_INCR    = 2'b01;
  localparam int          LINE_OFS_W    = 4;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_AR   = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_AW   = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wr_state_e;

endpackage

// File: rtl/cache_axi_arbiter_axi_wr_channel.sv
// DCache writeback engine: captures one line, then issues AW, four W beats
// and waits for B. Reports its buffered line so the reader can detect hazards.
module axi_wr_channel
  import cache_axi_arbiter_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_req_i,
  input  logic [31:LINE_OFS_W]   wr_line_i,
  input  logic [127:0]           wr_data_i,
  output logic                   wr_rdy_o,
  output logic [31:LINE_OFS_W]   wr_line_o,
  output logic [31:0]            awaddr_o,
  output logic                   awvalid_o,
  input  logic                   awready_i,
  output logic [31:0]            wdata_o,
  output logic                   wlast_o,
  output logic                   wvalid_o,
  input  logic                   wready_i,
  input  logic                   bvalid_i,
  output logic                   bready_o,
  output wr_state_e              state_o
);

  wr_state_e                state_q, state_d;
  logic [127:0]             buf_q, buf_d;
  logic [31:LINE_OFS_W]     line_q, line_d;
  logic [1:0]               cnt_q, cnt_d;
  logic                     last_beat;

  assign last_beat = (cnt_q == 2'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= W_IDLE;
      buf_q   <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    case (state_q)
      W_IDLE: begin
        if (wr_req_i) begin
          buf_d   = wr_data_i;
          line_d  = wr_line_i;
          state_d = W_AW;
        end
      end
      W_AW: begin
        if (awready_i) state_d = W_DATA;
      end
      W_DATA: begin
        if (wready_i) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = W_RESP;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      W_RESP: begin
        if (bvalid_i) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign wr_rdy_o  = (state_q == W_IDLE);
  assign wr_line_o = line_q;
  assign awaddr_o  = {line_q, {LINE_OFS_W{1'b0}}};
  assign awvalid_o = (state_q == W_AW);
  assign wvalid_o  = (state_q == W_DATA);
  assign wlast_o   = wvalid_o & last_beat;
  // Word 0 of the line sits in the low 32 bits of the buffer.
  assign wdata_o   = buf_q[{cnt_q, 5'b0} +: 32];
  assign bready_o  = (state_q == W_RESP);
  assign state_o   = state_q;

endmodule

// File: rtl/cache_axi_arbiter.sv
// Shares one AXI3 master between ICache refills, DCache refills and DCache
// writebacks. Define ARB_RR_EN for round-robin reads; default is DCache-first.
module cache_axi_arbiter
  import cache_axi_arbiter_pkg::*;
#(
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_rd_req,
  input  logic [31:0]   i_rd_addr,
  output logic          i_rd_rdy,
  input  logic          d_rd_req,
  input  logic [31:0]   d_rd_addr,
  output logic          d_rd_rdy,
  output logic          ret_valid,
  output logic          ret_sel,
  output logic          ret_last,
  output logic [31:0]   ret_data,
  input  logic          d_wr_req,
  input  logic [31:0]   d_wr_addr,
  input  logic [127:0]  d_wr_data,
  output logic          d_wr_rdy,
  output logic [31:0]   araddr,
  output logic [3:0]    arlen,
  output logic [2:0]    arsize,
  output logic [1:0]    arburst,
  output logic          arvalid,
  input  logic          arready,
  input  logic [31:0]   rdata,
  input  logic          rvalid,
  input  logic          rlast,
  output logic          rready,
  output logic [31:0]   awaddr,
  output logic [3:0]    awlen,
  output logic [2:0]    awsize,
  output logic [1:0]    awburst,
  output logic          awvalid,
  input  logic          awready,
  output logic [31:0]   wdata,
  output logic [3:0]    wstrb,
  output logic          wlast,
  output logic          wvalid,
  input  logic          wready,
  input  logic          bvalid,
  output logic          bready,
  output rd_state_e     dbg_rd_state_o,
  output wr_state_e     dbg_wr_state_o
);

  // Handshake rule on every channel: a transfer happens on a rising clk edge
  // where valid and ready are both high; valid and payload hold until then.

  rd_state_e             rd_state_q, rd_state_d;
  logic [31:0]           araddr_q, araddr_d;
  logic                  owner_q, owner_d;
  logic                  wr_idle, wr_accept;
  logic [31:LINE_OFS_W]  wr_line;
  logic                  i_haz, d_haz, i_elig, d_elig, grant_i, grant_d;
  logic                  unused_ofs;

  assign unused_ofs = ^{i_rd_addr[LINE_OFS_W-1:0], d_rd_addr[LINE_OFS_W-1:0],
                        d_wr_addr[LINE_OFS_W-1:0]};

  axi_wr_channel #(.BURST_LEN(BURST_LEN)) u_wr (
    .clk       (clk),
    .reset     (reset),
    .wr_req_i  (d_wr_req),
    .wr_line_i (d_wr_addr[31:LINE_OFS_W]),
    .wr_data_i (d_wr_data),
    .wr_rdy_o  (wr_idle),
    .wr_line_o (wr_line),
    .awaddr_o  (awaddr),
    .awvalid_o (awvalid),
    .awready_i (awready),
    .wdata_o   (wdata),
    .wlast_o   (wlast),
    .wvalid_o  (wvalid),
    .wready_i  (wready),
    .bvalid_i  (bvalid),
    .bready_o  (bready),
    .state_o   (dbg_wr_state_o)
  );

  // A read may not overtake a writeback of the same line, including one
  // being captured in this very cycle.
  assign wr_accept = d_wr_req & wr_idle;
  assign i_haz = (~wr_idle & (i_rd_addr[31:LINE_OFS_W] == wr_line)) |
                 (wr_accept & (i_rd_addr[31:LINE_OFS_W] == d_wr_addr[31:LINE_OFS_W]));
  assign d_haz = (~wr_idle & (d_rd_addr[31:LINE_OFS_W] == wr_line)) |
                 (wr_accept & (d_rd_addr[31:LINE_OFS_W] == d_wr_addr[31:LINE_OFS_W]));
  assign i_elig = i_rd_req & ~i_haz;
  assign d_elig = d_rd_req & ~d_haz;

`ifdef ARB_RR_EN
  logic rr_q, rr_d;  // 1: DCache wins the next contested round

  always_ff @(posedge clk) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end

  always_comb begin
    rr_d = rr_q;
    if ((rd_state_q == R_IDLE) && (i_elig | d_elig)) rr_d = ~grant_d;
  end

  assign grant_d = d_elig & (~i_elig | rr_q);
`else
  assign grant_d = d_elig;
`endif
  assign grant_i = i_elig & ~grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      araddr_q   <= '0;
      owner_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      araddr_q   <= araddr_d;
      owner_q    <= owner_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    owner_d    = owner_q;
    i_rd_rdy   = 1'b0;
    d_rd_rdy   = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (grant_d) begin
          d_rd_rdy   = 1'b1;
          araddr_d   = {d_rd_addr[31:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
          owner_d    = 1'b1;
          rd_state_d = R_AR;
        end else if (grant_i) begin
          i_rd_rdy   = 1'b1;
          araddr_d   = {i_rd_addr[31:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
          owner_d    = 1'b0;
          rd_state_d = R_AR;
        end
      end
      R_AR: begin
        if (arready) rd_state_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid && rlast) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign araddr         = araddr_q;
  assign arvalid        = (rd_state_q == R_AR);
  assign arlen          = 4'(BURST_LEN - 1);
  assign arsize         = AXSIZE_WORD;
  assign arburst        = BURST_INCR;
  assign rready         = (rd_state_q == R_DATA);
  assign ret_valid      = rready & rvalid;
  assign ret_sel        = owner_q;
  assign ret_last       = ret_valid & rlast;
  assign ret_data       = rdata;
  assign awlen          = 4'(BURST_LEN - 1);
  assign awsize         = AXSIZE_WORD;
  assign awburst        = BURST_INCR;
  assign wstrb          = 4'hf;
  assign d_wr_rdy       = wr_idle;
  assign dbg_rd_state_o = rd_state_q;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Bench for cache_axi_arbiter: reactive AXI slave with random readiness,
// expected-queue scoreboard, directed scenarios and a randomized model run.
module tb_cache_axi_arbiter;
  import cache_axi_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic i_rd_req = 0, d_rd_req = 0, d_wr_req = 0;
  logic [31:0] i_rd_addr = 0, d_rd_addr = 0, d_wr_addr = 0;
  logic [127:0] d_wr_data = 0;
  logic i_rd_rdy, d_rd_rdy, d_wr_rdy, ret_valid, ret_sel, ret_last;
  logic [31:0] ret_data, araddr, awaddr, wdata, rdata;
  logic [3:0] arlen, awlen, wstrb;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst;
  logic arvalid, arready, rvalid, rlast, rready, awvalid, awready;
  logic wlast, wvalid, wready, bvalid, bready;
  rd_state_e dbg_rd;
  wr_state_e dbg_wr;

  cache_axi_arbiter #(.BURST_LEN(4)) dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .ret_valid(ret_valid), .ret_sel(ret_sel), .ret_last(ret_last), .ret_data(ret_data),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .dbg_rd_state_o(dbg_rd), .dbg_wr_state_o(dbg_wr)
  );

  int checks = 0;
  int errors = 0;

  logic [33:0] exp_r_q[$];   // {sel, last, data}
  logic [32:0] exp_w_q[$];   // {last, data}
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_aw_q[$];

  bit   stall = 0;
  int   pct = 60;
  bit   r_act = 0;
  logic [31:0] r_addr = 0;
  int   r_beat = 0;
  bit   b_pend = 0;

  function automatic logic [31:0] rmem(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h0bad_f00d;
  endfunction

  task automatic push_read(input logic sel, input logic [31:0] addr);
    logic [31:0] base;
    base = {addr[31:4], 4'b0};
    exp_ar_q.push_back(base);
    for (int b = 0; b < 4; b++)
      exp_r_q.push_back({sel, (b == 3), rmem(base + 32'(b) * 4)});
  endtask

  task automatic push_write(input logic [31:0] addr, input logic [127:0] data);
    exp_aw_q.push_back({addr[31:4], 4'b0});
    for (int b = 0; b < 4; b++)
      exp_w_q.push_back({(b == 3), data[32*b +: 32]});
  endtask

  // AXI slave + scoreboard: bookkeeping at negedge, new drive at posedge+1.
  initial begin
    logic [33:0] er;
    logic [32:0] ew;
    logic [31:0] ea;
    arready = 0; rvalid = 0; rdata = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        r_act = 0; b_pend = 0; r_beat = 0;
      end else begin
        if (arvalid && arready) begin
          checks++;
          ea = (exp_ar_q.size() > 0) ? exp_ar_q.pop_front() : 32'hdead_beef;
          if (araddr !== ea || arlen !== 4'd3 || arsize !== 3'd2 || arburst !== 2'b01) begin
            errors++;
            $display("FAIL ar_beat araddr=%h len=%0d size=%0d burst=%0d want addr=%h len=3 size=2 burst=1",
                     araddr, arlen, arsize, arburst, ea);
          end
          r_act = 1; r_addr = araddr; r_beat = 0;
        end
        if (rvalid && rready) begin
          checks++;
          er = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : '1;
          if ({ret_valid, ret_sel, ret_last, ret_data} !== {1'b1, er}) begin
            errors++;
            $display("FAIL ret_beat got v=%b sel=%b last=%b data=%h want v=1 sel=%b last=%b data=%h",
                     ret_valid, ret_sel, ret_last, ret_data, er[33], er[32], er[31:0]);
          end
          r_beat++;
          if (rlast) r_act = 0;
        end
        if (awvalid && awready) begin
          checks++;
          ea = (exp_aw_q.size() > 0) ? exp_aw_q.pop_front() : 32'hdead_beef;
          if (awaddr !== ea || awlen !== 4'd3 || awsize !== 3'd2 || awburst !== 2'b01) begin
            errors++;
            $display("FAIL aw_beat awaddr=%h len=%0d size=%0d burst=%0d want addr=%h len=3 size=2 burst=1",
                     awaddr, awlen, awsize, awburst, ea);
          end
        end
        if (wvalid && wready) begin
          checks++;
          ew = (exp_w_q.size() > 0) ? exp_w_q.pop_front() : '1;
          if ({wlast, wdata, wstrb} !== {ew, 4'hf}) begin
            errors++;
            $display("FAIL w_beat got last=%b data=%h strb=%h want last=%b data=%h strb=f",
                     wlast, wdata, wstrb, ew[32], ew[31:0]);
          end
          if (wlast) b_pend = 1;
        end
        if (bvalid && bready) b_pend = 0;
      end
      @(posedge clk); #1;
      if (reset) begin
        arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
      end else begin
        arready = stall ? 1'b1 : ($urandom_range(0, 99) < pct);
        awready = stall ? 1'b1 : ($urandom_range(0, 99) < pct);
        wready  = stall ? 1'b0 : ($urandom_range(0, 99) < pct);
        rvalid  = r_act && !stall && ($urandom_range(0, 99) < pct);
        rdata   = rmem(r_addr + 32'(r_beat) * 4);
        rlast   = r_act && (r_beat == 3);
        bvalid  = b_pend && ($urandom_range(0, 99) < pct);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1; i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
    tick();
    tick();
    exp_r_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_aw_q.delete();
    reset = 0;
    sample();
  endtask

  task automatic wait_idle(input string what);
    int n;
    n = 0;
    while ((exp_r_q.size() || exp_w_q.size() || exp_ar_q.size() || exp_aw_q.size() || b_pend)
           && n < 2000) begin
      sample();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_timeout pending r=%0d w=%0d want all drained", what,
               exp_r_q.size(), exp_w_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, ret_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_valids got %b want 000000",
               {arvalid, awvalid, wvalid, rready, bready, ret_valid});
    end
    checks++;
    if (araddr !== 32'h0 || awaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr araddr=%h awaddr=%h want 0 0", araddr, awaddr);
    end
    checks++;
    if (d_wr_rdy !== 1'b1 || i_rd_rdy !== 1'b0 || d_rd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy wr=%b i=%b d=%b want 1 0 0", d_wr_rdy, i_rd_rdy, d_rd_rdy);
    end
    checks++;
    if (dbg_rd !== R_IDLE || dbg_wr !== W_IDLE) begin
      errors++;
      $display("FAIL reset_state rd=%0d wr=%0d want 0 0", dbg_rd, dbg_wr);
    end
  endtask

  task automatic test_icache_read();
    tick();
    i_rd_req = 1; i_rd_addr = 32'h1fc0_0384;
    sample();
    checks++;
    if (i_rd_rdy !== 1'b1 || d_rd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL icache_accept i=%b d=%b want 1 0", i_rd_rdy, d_rd_rdy);
    end
    push_read(1'b0, 32'h1fc0_0384);
    tick();
    i_rd_req = 0;
    sample();
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h1fc0_0380 || arlen !== 4'd3) begin
      errors++;
      $display("FAIL icache_ar arvalid=%b araddr=%h arlen=%0d want 1 1fc00380 3",
               arvalid, araddr, arlen);
    end
    wait_idle("icache_read");
  endtask

  task automatic test_arbitration();
    logic exp_sel[$];
    int i_left, d_left, got, n;
    logic gsel;
    logic [31:0] ia, da;
    do_reset();
`ifdef ARB_RR_EN
    exp_sel = '{1'b0, 1'b1, 1'b0};
    i_left = 2; d_left = 1;
`else
    exp_sel = '{1'b1, 1'b0};
    i_left = 1; d_left = 1;
`endif
    ia = 32'h0000_4004; da = 32'h0000_5008;
    tick();
    i_rd_req = 1; i_rd_addr = ia; d_rd_req = 1; d_rd_addr = da;
    got = 0; n = 0;
    while (got < exp_sel.size() && n < 1000) begin
      sample();
      n++;
      if (i_rd_rdy || d_rd_rdy) begin
        gsel = d_rd_rdy;
        checks++;
        if ((i_rd_rdy && d_rd_rdy) || gsel !== exp_sel[got]) begin
          errors++;
          $display("FAIL arb_round%0d i=%b d=%b want sel=%b", got, i_rd_rdy, d_rd_rdy, exp_sel[got]);
        end
        push_read(gsel, gsel ? da : ia);
        got++;
        tick();
        if (gsel) begin
          d_left--;
          d_rd_req = 0;
        end else begin
          i_left--;
          ia = ia + 32'h40;
          i_rd_addr = ia;
          i_rd_req = (i_left > 0);
        end
      end else begin
        tick();
      end
    end
    checks++;
    if (got < exp_sel.size()) begin
      errors++;
      $display("FAIL arb_timeout grants=%0d want %0d", got, exp_sel.size());
    end
    i_rd_req = 0; d_rd_req = 0;
    wait_idle("arbitration");
  endtask

  task automatic test_writeback_hazard();
    logic [127:0] data;
    bit prev_b, done;
    int n;
    data = {32'h44, 32'h33, 32'h22, 32'h11};
    tick();
    d_wr_req = 1; d_wr_addr = 32'h0000_1230; d_wr_data = data;
    d_rd_req = 1; d_rd_addr = 32'h0000_1238;
    sample();
    checks++;
    if (d_wr_rdy !== 1'b1 || d_rd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL wb_capture wr_rdy=%b rd_rdy=%b want 1 0", d_wr_rdy, d_rd_rdy);
    end
    push_write(32'h0000_1230, data);
    tick();
    d_wr_req = 0;
    prev_b = 0; done = 0; n = 0;
    while (!done && n < 1000) begin
      sample();
      n++;
      checks++;
      if (prev_b) begin
        if (d_wr_rdy !== 1'b1 || d_rd_rdy !== 1'b1) begin
          errors++;
          $display("FAIL wb_release wr_rdy=%b rd_rdy=%b want 1 1", d_wr_rdy, d_rd_rdy);
        end
        push_read(1'b1, 32'h0000_1238);
        done = 1;
      end else if (d_wr_rdy !== 1'b0 || d_rd_rdy !== 1'b0) begin
        errors++;
        $display("FAIL wb_blocked wr_rdy=%b rd_rdy=%b want 0 0", d_wr_rdy, d_rd_rdy);
      end
      prev_b = bvalid && bready;
      tick();
    end
    d_rd_req = 0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wb_timeout no bvalid handshake want one");
    end
    wait_idle("writeback");
  endtask

  task automatic test_concurrent();
    logic [127:0] data;
    data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    d_wr_req = 1; d_wr_addr = 32'h0000_2000; d_wr_data = data;
    d_rd_req = 1; d_rd_addr = 32'h0000_3004;
    sample();
    checks++;
    if (d_wr_rdy !== 1'b1 || d_rd_rdy !== 1'b1) begin
      errors++;
      $display("FAIL concur_accept wr_rdy=%b rd_rdy=%b want 1 1", d_wr_rdy, d_rd_rdy);
    end
    push_write(32'h0000_2000, data);
    push_read(1'b1, 32'h0000_3004);
    tick();
    d_wr_req = 0; d_rd_req = 0;
    sample();
    checks++;
    if (arvalid !== 1'b1 || awvalid !== 1'b1) begin
      errors++;
      $display("FAIL concur_addr arvalid=%b awvalid=%b want 1 1", arvalid, awvalid);
    end
    wait_idle("concurrent");
  endtask

  task automatic test_reset_mid_burst();
    stall = 1;
    tick();
    i_rd_req = 1; i_rd_addr = 32'h0000_6000;
    d_wr_req = 1; d_wr_addr = 32'h0000_7000; d_wr_data = '1;
    exp_ar_q.push_back(32'h0000_6000);
    exp_aw_q.push_back(32'h0000_7000);
    tick();
    i_rd_req = 0; d_wr_req = 0;
    tick();
    tick();
    sample();
    checks++;
    if (rready !== 1'b1 || wvalid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup rready=%b wvalid=%b want 1 1", rready, wvalid);
    end
    tick();
    reset = 1;
    tick();
    reset = 0;
    sample();
    checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, ret_valid} !== 6'b0 || d_wr_rdy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle valids=%b wr_rdy=%b want 000000 1",
               {arvalid, awvalid, wvalid, rready, bready, ret_valid}, d_wr_rdy);
    end
    exp_r_q.delete(); exp_w_q.delete(); exp_ar_q.delete(); exp_aw_q.delete();
    stall = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h0000_8000 + (32'($urandom_range(0, 3)) << 4) + 32'($urandom_range(0, 15));
  endfunction

  task automatic test_random();
    bit i_p, d_p, w_p, m_rd_busy, m_wr_busy, m_rr, wr_acc, ie, de, ei, ed;
    logic [31:0] ia, da, wa;
    logic [127:0] wd;
    logic [27:0] m_line;
    do_reset();
    i_p = 0; d_p = 0; w_p = 0; m_rd_busy = 0; m_wr_busy = 0; m_rr = 0;
    ia = 0; da = 0; wa = 0; wd = 0; m_line = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      if (!i_p && $urandom_range(0, 99) < 40) begin i_p = 1; ia = rand_addr(); end
      if (!d_p && $urandom_range(0, 99) < 40) begin d_p = 1; da = rand_addr(); end
      if (!w_p && $urandom_range(0, 99) < 25) begin
        w_p = 1; wa = rand_addr(); wd = {$urandom, $urandom, $urandom, $urandom};
      end
      i_rd_req = i_p; i_rd_addr = ia;
      d_rd_req = d_p; d_rd_addr = da;
      d_wr_req = w_p; d_wr_addr = wa; d_wr_data = wd;
      sample();
      checks++;
      if (d_wr_rdy !== !m_wr_busy) begin
        errors++;
        $display("FAIL rnd_wr_rdy cyc=%0d got %b want %b", cyc, d_wr_rdy, !m_wr_busy);
      end
      wr_acc = w_p && !m_wr_busy;
      ie = i_p && !m_rd_busy &&
           !((m_wr_busy && ia[31:4] == m_line) || (wr_acc && ia[31:4] == wa[31:4]));
      de = d_p && !m_rd_busy &&
           !((m_wr_busy && da[31:4] == m_line) || (wr_acc && da[31:4] == wa[31:4]));
`ifdef ARB_RR_EN
      ed = de && (!ie || m_rr);
`else
      ed = de;
`endif
      ei = ie && !ed;
      checks++;
      if (i_rd_rdy !== ei || d_rd_rdy !== ed) begin
        errors++;
        $display("FAIL rnd_grant cyc=%0d got i=%b d=%b want i=%b d=%b", cyc,
                 i_rd_rdy, d_rd_rdy, ei, ed);
      end
      if (m_rd_busy && rvalid && rlast) m_rd_busy = 0;
      if (m_wr_busy && bvalid && bready) m_wr_busy = 0;
      if (ed) begin push_read(1'b1, da); d_p = 0; m_rd_busy = 1; m_rr = 0; end
      if (ei) begin push_read(1'b0, ia); i_p = 0; m_rd_busy = 1; m_rr = 1; end
      if (wr_acc) begin push_write(wa, wd); w_p = 0; m_wr_busy = 1; m_line = wa[31:4]; end
    end
    tick();
    i_rd_req = 0; d_rd_req = 0; d_wr_req = 0;
    wait_idle("random");
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_arbitration();
    test_writeback_hazard();
    test_concurrent();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
